// File: rtl/needle_heystack_framer_pkg.sv
// Shared constants for the needle/heystack framer: byte width and FSM state encodings.
package needle_heystack_framer_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] FRAMER_IDLE     = 2'd0;
  localparam logic [1:0] FRAMER_NEEDLE   = 2'd1;
  localparam logic [1:0] FRAMER_HEYSTACK = 2'd2;

endpackage

// File: rtl/byte_stream_output_register.sv
// One-entry data/valid/last holding register for a byte stream with valid/ready backpressure.
module byte_stream_output_register
  import needle_heystack_framer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_adv,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last
);

  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;

  // A new byte may enter when the slot is empty or is being drained this cycle.
  assign o_adv = enable && (!r_valid || i_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load && o_adv) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (enable && r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/needle_heystack_framer.sv
// Frames a parallel needle word followed by a heystack byte stream into one output byte stream.
module needle_heystack_framer
  import needle_heystack_framer_pkg::*;
#(
  parameter int STRING_SIZE = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [STRING_SIZE*BYTE_W-1:0] needle,
  input  logic                          needle_valid,
  output logic                          needle_ready,
  input  logic [BYTE_W-1:0]             heystack_data,
  input  logic                          heystack_valid,
  input  logic                          heystack_last,
  output logic                          heystack_ready,
  output logic [BYTE_W-1:0]             out_data,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int              IDX_W    = (STRING_SIZE > 1) ? $clog2(STRING_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STRING_SIZE - 1);

  logic [1:0]                    r_state;
  logic [IDX_W-1:0]              r_index;
  logic [STRING_SIZE*BYTE_W-1:0] r_shadow;

  logic [BYTE_W-1:0] w_bytes [STRING_SIZE];
  logic [BYTE_W-1:0] w_needle_byte;
  logic [BYTE_W-1:0] w_load_data;
  logic              w_load_last;
  logic              w_load;
  logic              w_adv;
  logic              w_needle_acc;
  logic              w_hey_acc;

  // Byte 0 of the needle is the most significant byte of the word.
  genvar gi;
  generate
    for (gi = 0; gi < STRING_SIZE; gi++) begin : g_bytes
      assign w_bytes[gi] = r_shadow[(STRING_SIZE-gi)*BYTE_W-1 -: BYTE_W];
    end
  endgenerate

  always_comb begin
    w_needle_byte = '0;
    for (int i = 0; i < STRING_SIZE; i++) begin
      if (r_index == IDX_W'(i)) w_needle_byte = w_bytes[i];
    end
  end

  assign needle_ready   = !reset && enable && (r_state == FRAMER_IDLE);
  assign heystack_ready = !reset && w_adv && (r_state == FRAMER_HEYSTACK);
  assign w_needle_acc   = needle_valid && needle_ready;
  assign w_hey_acc      = heystack_valid && heystack_ready;

  assign w_load      = w_hey_acc || (w_adv && (r_state == FRAMER_NEEDLE));
  assign w_load_data = (r_state == FRAMER_HEYSTACK) ? heystack_data : w_needle_byte;
  assign w_load_last = (r_state == FRAMER_HEYSTACK) && heystack_last;

  assign busy = (r_state != FRAMER_IDLE) || out_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= FRAMER_IDLE;
      r_index  <= '0;
      r_shadow <= '0;
    end else begin
      case (r_state)
        FRAMER_IDLE: begin
          if (w_needle_acc) begin
            r_shadow <= needle;
            r_index  <= '0;
            r_state  <= FRAMER_NEEDLE;
          end
        end
        FRAMER_NEEDLE: begin
          if (w_adv) begin
            if (r_index == LAST_IDX) begin
              r_index <= '0;
              r_state <= FRAMER_HEYSTACK;
            end else begin
              r_index <= r_index + IDX_W'(1);
            end
          end
        end
        FRAMER_HEYSTACK: begin
          if (w_hey_acc && heystack_last) r_state <= FRAMER_IDLE;
        end
        default: r_state <= FRAMER_IDLE;
      endcase
    end
  end

  byte_stream_output_register u_out_reg (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_last  (w_load_last),
    .i_ready (out_ready),
    .o_adv   (w_adv),
    .o_data  (out_data),
    .o_valid (out_valid),
    .o_last  (out_last)
  );

endmodule

// File: tb/tb_needle_heystack_framer.sv
// Randomized and directed bench for needle_heystack_framer against a frame-level reference model.
module tb_needle_heystack_framer;

  localparam int SS = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [SS*8-1:0] needle = '0;
  logic          needle_valid = 1'b0;
  logic          needle_ready;
  logic [7:0]    heystack_data = '0;
  logic          heystack_valid = 1'b0;
  logic          heystack_last = 1'b0;
  logic          heystack_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b1;
  logic          busy;

  needle_heystack_framer #(.STRING_SIZE(SS)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .needle         (needle),
    .needle_valid   (needle_valid),
    .needle_ready   (needle_ready),
    .heystack_data  (heystack_data),
    .heystack_valid (heystack_valid),
    .heystack_last  (heystack_last),
    .heystack_ready (heystack_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Upstream sources: pending needle words and heystack bytes ({last, data}).
  logic [SS*8-1:0] needle_q[$];
  logic [8:0]      hey_q[$];
  int              pv = 100;
  int              ph = 100;

  always @(posedge clock) begin
    #1;
    if (needle_q.size() > 0 && $urandom_range(0, 99) < pv) begin
      needle_valid = 1'b1;
      needle       = needle_q[0];
    end else begin
      needle_valid = 1'b0;
      needle       = (SS*8)'($urandom);
    end
    if (hey_q.size() > 0 && $urandom_range(0, 99) < ph) begin
      heystack_valid = 1'b1;
      heystack_data  = hey_q[0][7:0];
      heystack_last  = hey_q[0][8];
    end else begin
      heystack_valid = 1'b0;
      heystack_data  = 8'($urandom);
      heystack_last  = 1'($urandom);
    end
  end

  // Reference model: which phase of the frame we are in, the needle bytes still to send,
  // and the contents of the single output slot.
  typedef enum int {M_IDLE, M_NEEDLE, M_HEY} phase_t;
  phase_t     m_phase = M_IDLE;
  logic [7:0] m_pend[$];
  logic       m_ov = 1'b0;
  logic [7:0] m_od = '0;
  logic       m_ol = 1'b0;
  bit         started = 0;
  logic [8:0] cap_q[$];

  logic       e_adv, e_nr, e_hr, ld;
  logic [7:0] ld_d;
  logic       ld_l;
  logic [8:0] drop;

  always @(negedge clock) begin
    if (started) begin
      e_adv = enable && (!m_ov || out_ready);
      e_nr  = !reset && enable && (m_phase == M_IDLE);
      e_hr  = !reset && e_adv && (m_phase == M_HEY);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("out_last", out_last, m_ol);
      chk("busy", busy, (m_phase != M_IDLE) || m_ov);
      chk("needle_ready", needle_ready, e_nr);
      chk("heystack_ready", heystack_ready, e_hr);
      if (!reset && enable && out_valid && out_ready) cap_q.push_back({out_last, out_data});

      if (reset) begin
        if (m_phase != M_IDLE) begin
          while (hey_q.size() > 0) begin
            drop = hey_q.pop_front();
            if (drop[8]) break;
          end
        end
        m_phase = M_IDLE;
        m_pend.delete();
        m_ov = 1'b0;
        m_od = '0;
        m_ol = 1'b0;
      end else begin
        ld = 1'b0;
        ld_d = '0;
        ld_l = 1'b0;
        case (m_phase)
          M_IDLE: if (e_nr && needle_valid) begin
            for (int i = 0; i < SS; i++) m_pend.push_back(needle[8*(SS-i)-1 -: 8]);
            void'(needle_q.pop_front());
            m_phase = M_NEEDLE;
          end
          M_NEEDLE: if (e_adv) begin
            ld = 1'b1;
            ld_d = m_pend.pop_front();
            if (m_pend.size() == 0) m_phase = M_HEY;
          end
          default: if (e_hr && heystack_valid) begin
            ld = 1'b1;
            ld_d = heystack_data;
            ld_l = heystack_last;
            void'(hey_q.pop_front());
            if (heystack_last) m_phase = M_IDLE;
          end
        endcase
        if (ld) begin
          m_ov = 1'b1;
          m_od = ld_d;
          m_ol = ld_l;
        end else if (m_ov && out_ready && enable) begin
          m_ov = 1'b0;
        end
      end
    end
  end

  task automatic push_frame(input logic [SS*8-1:0] nd, input logic [7:0] hs[$]);
    needle_q.push_back(nd);
    foreach (hs[i]) hey_q.push_back({(i == hs.size() - 1) ? 1'b1 : 1'b0, hs[i]});
  endtask

  task automatic wait_cap(input int n);
    int k = 0;
    while (cap_q.size() < n && k < 300) begin
      @(negedge clock);
      k++;
    end
    chk("cap_timeout", cap_q.size() >= n, 1);
  endtask

  task automatic cmp_stream(input string nm, input logic [8:0] exp[$]);
    chk({nm, "_len"}, cap_q.size(), exp.size());
    foreach (exp[i]) chk(nm, (i < cap_q.size()) ? cap_q[i] : 9'h1ff, exp[i]);
    cap_q.delete();
  endtask

  task automatic wait_byte(input logic [7:0] b);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 300) begin
      @(negedge clock);
      seen = !reset && out_valid && (out_data == b);
      k++;
    end
    chk("wait_byte", seen, 1);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (!(m_phase == M_IDLE && !m_ov && needle_q.size() == 0 && hey_q.size() == 0) && k < limit) begin
      @(negedge clock);
      k++;
    end
    chk("idle_timeout", k < limit, 1);
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hs[$];
    int k;
    @(posedge clock); #1;
    started = 1;
    @(negedge clock);
    chk("rst_needle_ready", needle_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_needle_ready", needle_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_data", out_data, 0);

    // Basic frame.
    cap_q.delete();
    hs = '{8'h78, 8'h79, 8'h7a};
    push_frame(24'h616263, hs);
    wait_cap(6);
    cmp_stream("frame1", '{9'h061, 9'h062, 9'h063, 9'h078, 9'h079, 9'h17a});
    wait_idle(100);

    // Backpressure on byte 62 with a second needle waiting.
    push_frame(24'h616263, hs);
    hs = '{8'h44, 8'h45};
    push_frame(24'h414243, hs);
    wait_byte(8'h61);
    @(posedge clock); #1;
    out_ready = 1'b0;
    @(negedge clock);
    chk("bp_hold_data", out_data, 8'h62);
    chk("bp_heystack_ready", heystack_ready, 0);
    chk("bp_needle_ready", needle_ready, 0);
    repeat (2) @(posedge clock);
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_cap(11);
    cmp_stream("frame2", '{9'h061, 9'h062, 9'h063, 9'h078, 9'h079, 9'h17a,
                           9'h041, 9'h042, 9'h043, 9'h044, 9'h145});
    wait_idle(100);

    // Single-byte heystack.
    hs = '{8'h00};
    push_frame(24'h616263, hs);
    wait_cap(4);
    cmp_stream("frame_single", '{9'h061, 9'h062, 9'h063, 9'h100});
    wait_idle(100);
    chk("single_idle_busy", busy, 0);

    // Enable low mid-needle.
    hs = '{8'h78, 8'h79, 8'h7a};
    push_frame(24'h616263, hs);
    wait_byte(8'h61);
    @(posedge clock); #1;
    enable = 1'b0;
    @(negedge clock);
    chk("en_hold_valid", out_valid, 1);
    chk("en_hold_data", out_data, 8'h62);
    repeat (1) @(posedge clock);
    @(posedge clock); #1;
    enable = 1'b1;
    wait_cap(6);
    cmp_stream("frame_en", '{9'h061, 9'h062, 9'h063, 9'h078, 9'h079, 9'h17a});
    wait_idle(100);

    // Reset during the heystack phase.
    push_frame(24'h616263, hs);
    wait_byte(8'h78);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_needle_ready", needle_ready, 1);
    cap_q.delete();
    hs = '{8'h55};
    push_frame(24'h616263, hs);
    wait_cap(4);
    cmp_stream("frame_after_rst", '{9'h061, 9'h062, 9'h063, 9'h155});
    wait_idle(100);

    // Randomized traffic.
    pv = 70;
    ph = 70;
    for (int f = 0; f < 40; f++) begin
      hs.delete();
      for (int b = 0; b < $urandom_range(1, 5); b++) hs.push_back(8'($urandom));
      push_frame((SS*8)'($urandom), hs);
    end
    k = 0;
    while (!(m_phase == M_IDLE && !m_ov && needle_q.size() == 0 && hey_q.size() == 0) && k < 20000) begin
      @(posedge clock); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      reset     = ($urandom_range(0, 299) == 0);
      k++;
    end
    chk("random_timeout", k < 20000, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
